modpow2q: RTL and testbench

Sequential modular power-of-two scaler for the Kyber-style arithmetic path. It computes b = a·2^n mod Q, with Q = 3329 by default. It is the inverse direction of the modular halving unit: one doubling step undoes one halving step. It restores values that were scaled by 2^-n, for example after repeated halving in inverse-NTT butterflies. Operands enter and results leave over valid/ready handshakes, and each doubling takes one clock.

---
 rtl/modpow2q_if.sv | 24 ++
 rtl/modpow2q.sv | 89 ++++++++
 tb/tb_modpow2q.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/modpow2q_if.sv
// Operand/result handshake bundle for modpow2q. The master modport drives operands and out_ready.
// The slave modport is the scaler, which returns b with in_ready and out_valid.
interface modpow2q_if #(
   parameter int WIDTH = 12,
   parameter int NW    = 4
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] a;
   logic [NW-1:0]    n;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] b;

   modport master (
      output in_valid, a, n, out_ready,
      input  in_ready, out_valid, b
   );

   modport slave (
      input  in_valid, a, n, out_ready,
      output in_ready, out_valid, b
   );
endinterface

// File: rtl/modpow2q.sv
// Computes b = a*2^n mod Q, one doubling per clock; out_valid rises n+1 cycles after accept.
// The result is held in DONE until out_ready; in_ready is high only in IDLE.
module modpow2q #(
   parameter int WIDTH = 12,
   parameter int Q     = 3329,
   parameter int NW    = 4
) (
   input  logic      clk,
   input  logic      rst,
   modpow2q_if.slave bus
);
   typedef enum logic [1:0] {S_IDLE, S_REDUCE, S_DOUBLE, S_DONE} state_t;

   localparam logic [WIDTH:0]  QX      = Q[WIDTH:0];
   localparam logic [NW-1:0]   CNT_ONE = {{(NW-1){1'b0}}, 1'b1};

   state_t           r_state;
   state_t           w_state_nxt;
   logic [WIDTH:0]   r_x;
   logic [WIDTH:0]   w_x_nxt;
   logic [WIDTH:0]   w_t;
   logic [NW-1:0]    r_cnt;
   logic [NW-1:0]    w_cnt_nxt;
   logic [WIDTH-1:0] r_b;
   logic             w_load_b;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:   if (bus.in_valid) w_state_nxt = S_REDUCE;
         S_REDUCE: w_state_nxt = (r_cnt == '0) ? S_DONE : S_DOUBLE;
         S_DOUBLE: if (r_cnt == CNT_ONE) w_state_nxt = S_DONE;
         S_DONE:   if (bus.out_ready) w_state_nxt = S_IDLE;
         default:  w_state_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      bus.in_ready  = (r_state == S_IDLE);
      bus.out_valid = (r_state == S_DONE);
   end

   assign bus.b = r_b;

   // x < Q before a doubling, so the top bit is free and 2x fits in WIDTH+1 bits.
   always_comb begin
      w_t       = {r_x[WIDTH-1:0], 1'b0};
      w_x_nxt   = r_x;
      w_cnt_nxt = r_cnt;
      case (r_state)
         S_IDLE: begin
            if (bus.in_valid) begin
               w_x_nxt   = {1'b0, bus.a};
               w_cnt_nxt = bus.n;
            end
         end
         S_REDUCE: w_x_nxt = (r_x >= QX) ? (r_x - QX) : r_x;
         S_DOUBLE: begin
            w_x_nxt   = (w_t >= QX) ? (w_t - QX) : w_t;
            w_cnt_nxt = r_cnt - CNT_ONE;
         end
         default: ;
      endcase
   end

   assign w_load_b = (w_state_nxt == S_DONE) && (r_state != S_DONE);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_x   <= '0;
         r_cnt <= '0;
         r_b   <= '0;
      end else begin
         r_x   <= w_x_nxt;
         r_cnt <= w_cnt_nxt;
         if (w_load_b) begin
            r_b <= w_x_nxt[WIDTH-1:0];
         end
      end
   end
endmodule

// File: tb/tb_modpow2q.sv
// Bench for modpow2q: directed vectors with literal results plus a cycle-level reference model.
// The monitor checks handshake timing and every presented result against that model.
module tb_modpow2q;
   localparam int QM = 3329;

   logic clk = 1'b0;
   logic rst = 1'b0;
   int   cyc = 0;
   int   n_vec = 0;
   int   n_miss = 0;
   int   n_taken = 0;

   modpow2q_if #(.WIDTH(12), .NW(4)) bus ();

   modpow2q #(.WIDTH(12), .Q(QM), .NW(4)) u_dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic int ref_pow(input int av, input int nv);
      int r;
      r = av % QM;
      for (int i = 0; i < nv; i++) r = (2 * r) % QM;
      return r;
   endfunction

   task automatic chk(input string nm, input int act, input int exp);
      n_vec++;
      if (act != exp) begin
         n_miss++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   // Model: one operand in flight; result appears n+1 edges after accept and persists until taken.
   bit m_pend = 1'b0;
   int m_exp  = 0;
   int m_due  = 0;

   always @(negedge clk) begin
      if (rst) begin
         chk("rst_out_valid", int'(bus.out_valid), 0);
         chk("rst_in_ready", int'(bus.in_ready), 1);
         chk("rst_b", int'(bus.b), 0);
         m_pend = 1'b0;
      end else begin
         chk("in_ready", int'(bus.in_ready), int'(!m_pend));
         if (m_pend) begin
            chk("out_valid_timing", int'(bus.out_valid), int'(cyc >= m_due));
            if (bus.out_valid) begin
               chk("b_model", int'(bus.b), m_exp);
               if (bus.out_ready) begin
                  m_pend = 1'b0;
                  n_taken++;
               end
            end
         end else begin
            chk("out_valid_idle", int'(bus.out_valid), 0);
         end
         if (bus.in_valid && bus.in_ready) begin
            m_pend = 1'b1;
            m_exp  = ref_pow(int'(bus.a), int'(bus.n));
            m_due  = cyc + 1 + int'(bus.n) + 1;
         end
      end
   end

   task automatic wait_out(input string nm, output bit ok);
      int t;
      t = 0;
      while (!bus.out_valid && t < 100) begin
         @(posedge clk); #1;
         t++;
      end
      ok = bus.out_valid;
      if (!ok) chk({nm, "_timeout"}, 0, 1);
   endtask

   task automatic do_op(input int av, input int nv, input int exp_b, input int exp_lat,
                        input string nm);
      int t;
      int acc;
      bit ok;
      t = 0;
      while (!bus.in_ready && t < 100) begin
         @(posedge clk); #1;
         t++;
      end
      bus.in_valid = 1'b1;
      bus.a        = 12'(av);
      bus.n        = 4'(nv);
      @(posedge clk); #1;
      acc          = cyc;
      bus.in_valid = 1'b0;
      wait_out(nm, ok);
      if (ok) begin
         chk({nm, "_b"}, int'(bus.b), exp_b);
         if (exp_lat >= 0) chk({nm, "_latency"}, cyc - acc, exp_lat);
         if (bus.out_ready) begin
            @(posedge clk); #1;
         end
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached, cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      bit ok;
      bit rdy;
      int av;
      int h;
      int prev_acc;
      int prev_n;
      int taken0;
      int n_acc;
      int guard;

      bus.in_valid  = 1'b0;
      bus.a         = '0;
      bus.n         = '0;
      bus.out_ready = 1'b1;
      #2;
      rst          = 1'b1;
      bus.in_valid = 1'b1;
      bus.a        = 12'd5;
      bus.n        = 4'd0;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      @(posedge clk); #1;
      chk("first_accept_in_ready", int'(bus.in_ready), 0);
      bus.in_valid = 1'b0;
      wait_out("first_op", ok);
      if (ok) chk("first_op_b", int'(bus.b), 5);
      @(posedge clk); #1;

      do_op(3, 1, 6, 2, "a3_n1");
      do_op(1665, 1, 1, 2, "a1665_n1");
      do_op(4095, 0, 766, 1, "a4095_n0");
      do_op(1, 12, 767, 13, "a1_n12");
      do_op(1, 15, 2807, 16, "a1_n15");
      do_op(1668, 1, 7, 2, "halve_7");

      for (int i = 0; i < 1000; i++) begin
         av = $urandom_range(0, QM - 1);
         h  = (av % 2 == 0) ? av / 2 : av / 2 + 1665;
         do_op(h, 1, av, 2, "inverse");
      end

      bus.out_ready = 1'b0;
      do_op(2, 3, 16, 4, "bp");
      for (int i = 0; i < 5; i++) begin
         chk("bp_b_stable", int'(bus.b), 16);
         chk("bp_in_ready", int'(bus.in_ready), 0);
         @(posedge clk); #1;
      end
      bus.out_ready = 1'b1;
      @(posedge clk); #1;
      chk("bp_release_in_ready", int'(bus.in_ready), 1);

      bus.in_valid = 1'b1;
      bus.a        = 12'd1;
      bus.n        = 4'd15;
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      repeat (8) @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      repeat (20) @(posedge clk);
      #1;
      chk("abort_b", int'(bus.b), 0);
      do_op(2, 2, 8, 3, "after_abort");

      bus.out_ready = 1'b1;
      prev_acc      = -1;
      prev_n        = 0;
      taken0        = n_taken;
      n_acc         = 0;
      guard         = 0;
      bus.a         = 12'($urandom_range(0, 4095));
      bus.n         = 4'($urandom_range(0, 15));
      bus.in_valid  = 1'b1;
      while (n_acc < 25 && guard < 2000) begin
         rdy = bus.in_ready;
         @(posedge clk); #1;
         guard++;
         if (rdy) begin
            if (prev_acc >= 0) chk("b2b_spacing", cyc - prev_acc, prev_n + 3);
            prev_acc = cyc;
            prev_n   = int'(bus.n);
            n_acc++;
            bus.a    = 12'($urandom_range(0, 4095));
            bus.n    = 4'($urandom_range(0, 15));
         end
      end
      bus.in_valid = 1'b0;
      repeat (20) @(posedge clk);
      #1;
      chk("b2b_accepts", n_acc, 25);
      chk("b2b_results", n_taken - taken0, n_acc);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end
endmodule
